// File: rtl/uphi_pkg.sv
// Shared types for the UPHI voltage collector: FSM states, serializer phases and DAC word layout.
// Pure declarations; no timing or flow control of its own.
package uphi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        COLLECT,
        DRAIN,
        DONE
    } uphi_state_t;

    // GAP covers the inter-word sync-high time and hosts the word-register load.
    typedef enum logic [1:0] {
        SER_GAP,
        SER_ARM,
        SER_SHIFT,
        SER_TAIL
    } uphi_ser_t;

    localparam int WORD_W  = 16;
    localparam int CMD_MSB = 15;
    localparam int CMD_LSB = 12;
    localparam int VOL_MSB = 11;
    localparam int VOL_LSB = 4;

    function automatic logic [WORD_W-1:0] uphi_word(input logic [3:0] cmd, input logic [7:0] vol);
        logic [WORD_W-1:0] w;
        w                  = '0;
        w[CMD_MSB:CMD_LSB] = cmd;
        w[VOL_MSB:VOL_LSB] = vol;
        return w;
    endfunction

endpackage

// File: rtl/uphi_frame_ram.sv
// Simple dual-port frame buffer, one write port and one registered read port.
// Read data appears one cycle after the address; no backpressure.
module uphi_frame_ram #(
    parameter int DEPTH = 720,
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             clk_in,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        if (i_rd_en) begin
            o_rd_dat <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/uphi_vol_collector.sv
// Requests a UPHI rebuild pass, buffers the emitted voltages, then shifts them out as 16-bit DAC words.
// Capture follows the rebuild block's window; the serial side is self-paced by SCLK_DIV and SYNC_GAP.
module uphi_vol_collector
    import uphi_pkg::*;
#(
    parameter int         UPHI_VOL_WIDTH = 8,
    parameter int         UPHI_VOL_NUM   = 720,
    parameter int         IDX_WIDTH      = 10,
    parameter int         SCLK_DIV       = 2,
    parameter logic [3:0] DAC_CMD        = 4'hC,
    parameter int         SYNC_GAP       = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      frame_req,
    output logic                      uphi_start,
    input  logic                      uphi_active,
    input  logic [1:0]                uphi_read_cnt,
    input  logic [UPHI_VOL_WIDTH-1:0] uphi_vol,
    output logic                      dac_sclk,
    output logic                      dac_sync_n,
    output logic                      dac_sdo,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      err_short,
    output logic                      err_extra
);

    localparam int                CNT_W = IDX_WIDTH + 1;
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(UPHI_VOL_NUM);
    localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);
    localparam logic [15:0]       DIV_LAST  = 16'(SCLK_DIV - 1);
    localparam logic [15:0]       GAP_LOAD  = 16'(SYNC_GAP - 2);
    localparam logic [15:0]       GAP_LAST  = 16'(SYNC_GAP - 1);

    uphi_state_t              r_state, w_state_nxt;
    uphi_ser_t                r_ser;
    logic [CNT_W-1:0]         r_cap_cnt;
    logic [CNT_W-1:0]         r_word_idx;
    logic                     r_active_d;
    logic [15:0]              r_tick;
    logic [3:0]               r_bit;
    logic [WORD_W-1:0]        r_shift;
    logic                     r_sclk;
    logic                     r_sync_n;
    logic                     r_err_short;
    logic                     r_err_extra;

    logic [UPHI_VOL_WIDTH-1:0] w_rd_dat;
    logic [7:0]                w_vol8;
    logic                      w_cap;
    logic                      w_room;
    logic                      w_fall;
    logic                      w_more;
    logic                      w_drain_end;

    assign w_cap       = (r_state == COLLECT) && uphi_active && (uphi_read_cnt == 2'd3);
    assign w_room      = (r_cap_cnt < FULL);
    assign w_fall      = r_active_d && !uphi_active;
    assign w_more      = (r_word_idx < r_cap_cnt);
    assign w_drain_end = (r_ser == SER_GAP) && !w_more && (r_tick == GAP_LAST);
    assign w_vol8      = 8'(w_rd_dat);

    // The read port follows r_word_idx continuously so the next word is ready long before its load.
    uphi_frame_ram #(
        .DEPTH (UPHI_VOL_NUM),
        .WIDTH (UPHI_VOL_WIDTH),
        .AW    (IDX_WIDTH)
    ) u_ram (
        .clk_in    (clk_in),
        .i_wr_en   (w_cap && w_room),
        .i_wr_addr (r_cap_cnt[IDX_WIDTH-1:0]),
        .i_wr_dat  (uphi_vol),
        .i_rd_en   (w_more),
        .i_rd_addr (r_word_idx[IDX_WIDTH-1:0]),
        .o_rd_dat  (w_rd_dat)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        uphi_start  = 1'b0;
        busy        = 1'b1;
        frame_done  = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (frame_req) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                uphi_start  = 1'b1;
                w_state_nxt = COLLECT;
            end
            COLLECT: begin
                if (!uphi_active && !w_room) begin
                    w_state_nxt = DRAIN;
                end else if (w_fall) begin
                    w_state_nxt = (r_cap_cnt == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_end) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cap_cnt   <= '0;
            r_word_idx  <= '0;
            r_active_d  <= 1'b0;
            r_ser       <= SER_GAP;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_sclk      <= 1'b0;
            r_sync_n    <= 1'b1;
            r_err_short <= 1'b0;
            r_err_extra <= 1'b0;
        end else begin
            r_active_d <= uphi_active;

            if (r_state == IDLE && frame_req) begin
                r_cap_cnt   <= '0;
                r_word_idx  <= '0;
                r_err_short <= 1'b0;
                r_err_extra <= 1'b0;
            end

            if (w_cap) begin
                if (w_room) begin
                    r_cap_cnt <= r_cap_cnt + ONE;
                end else begin
                    r_err_extra <= 1'b1;
                end
            end

            if (r_state == COLLECT && w_fall && w_room) begin
                r_err_short <= 1'b1;
            end

            // Enter the gap phase at its load point so the first word goes out without a dead gap.
            if (r_state == COLLECT && w_state_nxt == DRAIN) begin
                r_ser  <= SER_GAP;
                r_tick <= GAP_LOAD;
            end

            if (r_state == DRAIN) begin
                case (r_ser)
                    SER_GAP: begin
                        if (w_more && r_tick >= GAP_LOAD) begin
                            r_shift    <= uphi_word(DAC_CMD, w_vol8);
                            r_word_idx <= r_word_idx + ONE;
                            r_ser      <= SER_ARM;
                            r_tick     <= '0;
                        end else begin
                            r_tick <= r_tick + 16'd1;
                        end
                    end
                    SER_ARM: begin
                        r_sync_n <= 1'b0;
                        r_ser    <= SER_SHIFT;
                        r_tick   <= '0;
                        r_bit    <= '0;
                    end
                    SER_SHIFT: begin
                        if (r_tick == DIV_LAST) begin
                            r_tick <= '0;
                            r_sclk <= ~r_sclk;
                            if (r_sclk) begin
                                r_shift <= {r_shift[WORD_W-2:0], 1'b0};
                                r_bit   <= r_bit + 4'd1;
                                if (r_bit == 4'd15) begin
                                    r_ser <= SER_TAIL;
                                end
                            end
                        end else begin
                            r_tick <= r_tick + 16'd1;
                        end
                    end
                    SER_TAIL: begin
                        if (r_tick == DIV_LAST) begin
                            r_sync_n <= 1'b1;
                            r_ser    <= SER_GAP;
                            r_tick   <= '0;
                        end else begin
                            r_tick <= r_tick + 16'd1;
                        end
                    end
                    default: r_ser <= SER_GAP;
                endcase
            end
        end
    end

    assign dac_sclk   = r_sclk;
    assign dac_sync_n = r_sync_n;
    assign dac_sdo    = r_shift[WORD_W-1];
    assign err_short  = r_err_short;
    assign err_extra  = r_err_extra;

endmodule
